// File: rtl/img_pkg.sv
// Shared pixel-pipeline types and constants for the luma post-filter stages.
// The divide-by-7 helper uses a reciprocal multiply that is exact for T in 0..1785.
package img_pkg;
  localparam int PIX_W    = 8;
  localparam int RECIP7   = 37450;
  localparam int RECIP_SH = 18;
  localparam int PIPE_LAT = 6;
  localparam int CSUM_W   = 10;
  localparam int SUM_W    = 12;
  localparam int T_W      = 11;
  localparam int PROD_W   = 27;

  typedef logic [PIX_W-1:0] pix_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_t;

  function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
    pix_t m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
    pix_t m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic pix_t div7(input logic [T_W-1:0] t);
    return PIX_W'((PROD_W'(t) * PROD_W'(RECIP7)) >> RECIP_SH);
  endfunction
endpackage

// File: rtl/alpha_trim_mean_3x3_if.sv
// Video stream bundle: the source drives hsync/vsync/de/data every cycle.
// de qualifies data; there is no ready, the sink must accept every cycle.
interface alpha_trim_mean_3x3_if;
  import img_pkg::*;
  logic hsync;
  logic vsync;
  logic de;
  pix_t data;

  modport master (output hsync, vsync, de, data);
  modport slave  (input  hsync, vsync, de, data);
endinterface

// File: rtl/line_buf_2row.sv
// Two cascaded line RAMs holding rows r-1 and r-2, read-before-write at column col.
// Read data is registered so it lines up with the top level's S1 input register.
module line_buf_2row
  import img_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int CW    = 10
) (
  input  logic          clk,
  input  logic          rd_en_i,
  input  logic          wr_en_i,
  input  logic [CW-1:0] addr_i,
  input  pix_t          wdata_i,
  output pix_t          row1_o,
  output pix_t          row2_o
);
  pix_t mem0_q [IMG_W];
  pix_t mem1_q [IMG_W];
  pix_t row1_q, row2_q;

  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      row1_q <= mem0_q[addr_i];
      row2_q <= mem1_q[addr_i];
      if (wr_en_i) begin
        mem0_q[addr_i] <= wdata_i;
        mem1_q[addr_i] <= mem0_q[addr_i];
      end
    end
  end

  assign row1_o = row1_q;
  assign row2_o = row2_q;
endmodule

// File: rtl/alpha_trim_mean_3x3.sv
// Streaming 3x3 alpha-trimmed mean (drop one min and one max, average the other 7).
// Six-stage pipeline; syncs and de are delayed alongside the data path.
module alpha_trim_mean_3x3
  import img_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int CW    = 10
) (
  input logic                   clk,
  input logic                   rst_n,
  alpha_trim_mean_3x3_if.slave  in_i,
  alpha_trim_mean_3x3_if.master out_o
);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);

  logic          de_q, vs_q, ovl_q, ovl_d;
  logic [CW-1:0] col_q, col_d, row_q, row_d, row_eff;
  logic          de_fall, vs_rise, wr_en;

  assign de_fall = de_q & ~in_i.de;
  assign vs_rise = in_i.vsync & ~vs_q;
  // A pixel arriving with the vsync rising edge already belongs to row 0.
  assign row_eff = vs_rise ? '0 : row_q;
  assign wr_en   = in_i.de & ~ovl_q;

  always_comb begin
    col_d = col_q;
    ovl_d = ovl_q;
    row_d = row_q;
    if (in_i.de) begin
      if (col_q == COL_MAX) ovl_d = 1'b1;
      else                  col_d = col_q + CW'(1);
    end else if (de_fall) begin
      col_d = '0;
      ovl_d = 1'b0;
    end
    if (vs_rise)                         row_d = '0;
    else if (de_fall && (row_q != '1))   row_d = row_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q  <= 1'b0;
      vs_q  <= 1'b0;
      ovl_q <= 1'b0;
      col_q <= '0;
      row_q <= '0;
    end else begin
      de_q  <= in_i.de;
      vs_q  <= in_i.vsync;
      ovl_q <= ovl_d;
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  pix_t row1, row2;

  line_buf_2row #(.IMG_W(IMG_W), .CW(CW)) u_line_buf (
    .clk     (clk),
    .rd_en_i (in_i.de),
    .wr_en_i (wr_en),
    .addr_i  (col_q),
    .wdata_i (in_i.data),
    .row1_o  (row1),
    .row2_o  (row2)
  );

  sync_t                sync_q [PIPE_LAT];
  pix_t                 d1_q;
  logic                 r_ge1_q, r_ge2_q, c_ge1_q, c_ge2_q;
  pix_t                 win_q [3][3];
  logic [CSUM_W-1:0]    csum_q [3];
  pix_t                 cmin_q [3];
  pix_t                 cmax_q [3];
  logic [SUM_W-1:0]     sum_q;
  pix_t                 min_q, max_q;
  logic [T_W-1:0]       t_q;
  pix_t                 out_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) sync_q[i] <= '0;
      d1_q    <= '0;
      r_ge1_q <= 1'b0;
      r_ge2_q <= 1'b0;
      c_ge1_q <= 1'b0;
      c_ge2_q <= 1'b0;
      for (int c = 0; c < 3; c++) begin
        for (int r = 0; r < 3; r++) win_q[c][r] <= '0;
        csum_q[c] <= '0;
        cmin_q[c] <= '0;
        cmax_q[c] <= '0;
      end
      sum_q      <= '0;
      min_q      <= '0;
      max_q      <= '0;
      t_q        <= '0;
      out_data_q <= '0;
    end else begin
      sync_q[0] <= {in_i.hsync, in_i.vsync, in_i.de};
      for (int i = 1; i < PIPE_LAT; i++) sync_q[i] <= sync_q[i-1];
      // S1: input register plus border flags for the pixel's window
      d1_q    <= in_i.data;
      r_ge1_q <= (row_eff != '0);
      r_ge2_q <= (row_eff >= CW'(2));
      c_ge1_q <= (col_q != '0);
      c_ge2_q <= (col_q >= CW'(2));
      // S2: win_q[col][row], col 2 = newest column, row 2 = current line
      if (sync_q[0].de) begin
        for (int r = 0; r < 3; r++) begin
          win_q[0][r] <= c_ge2_q ? win_q[1][r] : '0;
          win_q[1][r] <= c_ge1_q ? win_q[2][r] : '0;
        end
        win_q[2][0] <= r_ge2_q ? row2 : '0;
        win_q[2][1] <= r_ge1_q ? row1 : '0;
        win_q[2][2] <= d1_q;
      end
      // S3
      for (int c = 0; c < 3; c++) begin
        csum_q[c] <= CSUM_W'(win_q[c][0]) + CSUM_W'(win_q[c][1]) + CSUM_W'(win_q[c][2]);
        cmin_q[c] <= min3(win_q[c][0], win_q[c][1], win_q[c][2]);
        cmax_q[c] <= max3(win_q[c][0], win_q[c][1], win_q[c][2]);
      end
      // S4
      sum_q <= SUM_W'(csum_q[0]) + SUM_W'(csum_q[1]) + SUM_W'(csum_q[2]);
      min_q <= min3(cmin_q[0], cmin_q[1], cmin_q[2]);
      max_q <= max3(cmax_q[0], cmax_q[1], cmax_q[2]);
      // S5: removing exactly one min and one max copy handles ties
      t_q <= T_W'(sum_q - SUM_W'(min_q) - SUM_W'(max_q));
      // S6
      out_data_q <= sync_q[PIPE_LAT-2].de ? div7(t_q) : '0;
    end
  end

  assign out_o.hsync = sync_q[PIPE_LAT-1].hsync;
  assign out_o.vsync = sync_q[PIPE_LAT-1].vsync;
  assign out_o.de    = sync_q[PIPE_LAT-1].de;
  assign out_o.data  = out_data_q;
endmodule

// File: tb/tb_alpha_trim_mean_3x3.sv
// Directed bench for alpha_trim_mean_3x3: image model feeds an expected queue,
// a negedge monitor pops it on out_de and checks the 6-cycle sync delay.
module tb_alpha_trim_mean_3x3;
  import img_pkg::*;

  localparam int IMG_W = 16;
  localparam int CW    = 4;
  localparam int W     = 9;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  alpha_trim_mean_3x3_if in_if ();
  alpha_trim_mean_3x3_if out_if ();

  alpha_trim_mean_3x3 #(.IMG_W(IMG_W), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in_i  (in_if),
    .out_o (out_if)
  );

  // clock / reset
  always #5 clk = ~clk;

  int           img [0:15][0:IMG_W+2];
  logic [W-1:0] exp_q[$];
  logic [2:0]   hist_q [6];
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    assert (got === expv) else begin
      n_errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  // reference: window rows r-2..r, cols c-2..c, out-of-image taps are 0
  function automatic int exp_pix(input int r, input int c);
    int s, mn, mx, v;
    s = 0; mn = 255; mx = 0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        if ((r - dr) < 0 || (c - dc) < 0) v = 0;
        else v = img[r-dr][c-dc];
        s += v;
        if (v < mn) mn = v;
        if (v > mx) mx = v;
      end
    end
    return (s - mn - mx) / 7;
  endfunction

  // scoreboard / monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst_n) begin
      chk("rst_outputs", 32'({out_if.hsync, out_if.vsync, out_if.de, out_if.data}), 32'd0);
      for (int i = 0; i < 6; i++) hist_q[i] <= '0;
    end else begin
      chk("sync_delay", 32'({out_if.hsync, out_if.vsync, out_if.de}), 32'(hist_q[5]));
      if (out_if.de) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_de", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (e[8]) chk("pixel", 32'(out_if.data), 32'(e[7:0]));
        end
      end else begin
        chk("idle_data_zero", 32'(out_if.data), 32'd0);
      end
      for (int i = 5; i > 0; i--) hist_q[i] <= hist_q[i-1];
      hist_q[0] <= {in_if.hsync, in_if.vsync, in_if.de};
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill_const(input int v);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < IMG_W + 3; c++) img[r][c] = v;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < IMG_W + 3; c++) img[r][c] = int'($urandom_range(0, 255));
  endtask

  task automatic drive_pix(input int r, input int c);
    in_if.de   = 1'b1;
    in_if.data = 8'(img[r][c]);
    exp_q.push_back({(c < IMG_W), 8'(exp_pix(r, c))});
    tick(1);
  endtask

  task automatic drive_line(input int r, input int len, input bit vs_first);
    for (int c = 0; c < len; c++) begin
      if (vs_first && c == 0) in_if.vsync = 1'b1;
      drive_pix(r, c);
    end
    in_if.de    = 1'b0;
    in_if.data  = '0;
    in_if.vsync = 1'b0;
    tick(int'($urandom_range(1, 3)));
    in_if.hsync = 1'b1;
    tick(1);
    in_if.hsync = 1'b0;
    tick(1);
  endtask

  task automatic start_frame();
    in_if.vsync = 1'b1;
    tick(2);
    in_if.vsync = 1'b0;
    tick(2);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk(tag, 32'({out_if.hsync, out_if.vsync, out_if.de, out_if.data}), 32'd0);
  endtask

  initial begin
    in_if.hsync = 1'b0;
    in_if.vsync = 1'b0;
    in_if.de    = 1'b0;
    in_if.data  = '0;
    #1 rst_n = 1'b0;
    tick(3);
    check_outputs_zero("reset_state");
    rst_n = 1'b1;
    tick(2);

    // constant 100, 8x6: 100 interior, 28/71 on the top/left borders
    fill_const(100);
    start_frame();
    for (int r = 0; r < 6; r++) drive_line(r, 8, 1'b0);

    // impulse 255 at (3,3) in a field of 10
    fill_const(10);
    img[3][3] = 255;
    start_frame();
    for (int r = 0; r < 7; r++) drive_line(r, 8, 1'b0);

    // all-255 frame: widest S and T
    fill_const(255);
    start_frame();
    for (int r = 0; r < 6; r++) drive_line(r, 8, 1'b0);

    // random frame whose first pixel coincides with the vsync rising edge
    fill_rand();
    drive_line(0, 8, 1'b1);
    for (int r = 1; r < 6; r++) drive_line(r, 8, 1'b0);

    // full-width frame with one overlong line (IMG_W+3 pixels)
    fill_rand();
    start_frame();
    drive_line(0, IMG_W, 1'b0);
    drive_line(1, IMG_W, 1'b0);
    drive_line(2, IMG_W + 3, 1'b0);
    drive_line(3, IMG_W, 1'b0);
    drive_line(4, IMG_W, 1'b0);

    // latency: one isolated pixel after an idle stream
    fill_const(200);
    start_frame();
    tick(8);
    drive_line(0, 1, 1'b0);
    tick(10);

    // reset in the middle of row 4 of a constant-100 frame
    fill_const(100);
    start_frame();
    for (int r = 0; r < 4; r++) drive_line(r, 8, 1'b0);
    for (int c = 0; c < 3; c++) drive_pix(4, c);
    in_if.de   = 1'b0;
    in_if.data = '0;
    rst_n      = 1'b0;
    exp_q.delete();
    #1;
    check_outputs_zero("rst_async");
    tick(1);
    check_outputs_zero("rst_next_edge");
    tick(2);
    rst_n = 1'b1;
    tick(3);
    for (int r = 0; r < 4; r++) drive_line(r, 8, 1'b0);

    // drain with a bounded wait
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick(1);
    chk("drain", 32'(exp_q.size()), 32'd0);
    tick(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
